// File: rtl/mux8_to_1.sv
// mux8_to_1: registered 8-to-1 single-bit selector.
//   Picks D[addy] and presents it on dout one clock later. valid qualifies
//   dout. Both outputs are plain flops, so no input reaches an output
//   without passing through a register.
// Ports:
//   clk   - sole clock, rising edge
//   rst   - synchronous, active-high reset; takes priority over en
//   en    - enable; a selection is captured only when high
//   D     - 8-bit candidate vector, D[k] is candidate k (k=0 is the LSB)
//   addy  - 3-bit select address; all 8 codes are legal
//   valid - high while dout holds a selected bit
//   dout  - registered selected bit
module mux8_to_1 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] D,
  input  logic [2:0] addy,
  output logic       valid,
  output logic       dout
);

  logic sel_bit;

  // A 3-bit index into an 8-bit vector always lands in range, so no
  // guard or default is needed.
  assign sel_bit = D[addy];

  // dout is forced low whenever the stage is idle rather than holding its
  // last value, so a stale bit never appears downstream, even if valid
  // were ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= 1'b0;
    end else if (en) begin
      valid <= 1'b1;
      dout  <= sel_bit;
    end else begin
      valid <= 1'b0;
      dout  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux8_to_1.sv
module tb_mux8_to_1;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] D;
  logic [2:0] addy;
  logic       valid;
  logic       dout;

  mux8_to_1 dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .D     (D),
    .addy  (addy),
    .valid (valid),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic [2:0] addy;
    logic       ev;
    logic       ed;
    string      name;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  int applied = 0;
  int miscompares = 0;
  bit done = 0;

  task automatic add(input logic r, input logic e, input logic [7:0] d,
                     input logic [2:0] a, input logic ev, input logic ed,
                     input string name);
    vec_t v;
    v.rst = r; v.en = e; v.d = d; v.addy = a; v.ev = ev; v.ed = ed; v.name = name;
    vecs.push_back(v);
  endtask

  // Monitor: every cycle the DUT presents a registered {valid,dout}; pop the
  // expectation queued by the driver for that edge and compare.
  initial begin
    vec_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        applied++;
        if (valid !== e.ev || dout !== e.ed) begin
          miscompares++;
          $display("FAIL %s: got valid=%b dout=%b, want valid=%b dout=%b",
                   e.name, valid, dout, e.ev, e.ed);
        end
      end
    end
  end

  initial begin
    int waited;
    rst = 1'b1; en = 1'b0; D = 8'h00; addy = 3'd0;

    // Reset holds outputs low even with en=1.
    add(1, 1, 8'hFF, 3'd3, 0, 0, "reset0");
    add(1, 1, 8'hFF, 3'd3, 0, 0, "reset1");
    // Address sweep over 8'b10101010: odd bits set.
    add(0, 1, 8'hAA, 3'd0, 1, 0, "sweep0");
    add(0, 1, 8'hAA, 3'd1, 1, 1, "sweep1");
    add(0, 1, 8'hAA, 3'd2, 1, 0, "sweep2");
    add(0, 1, 8'hAA, 3'd3, 1, 1, "sweep3");
    add(0, 1, 8'hAA, 3'd4, 1, 0, "sweep4");
    add(0, 1, 8'hAA, 3'd5, 1, 1, "sweep5");
    add(0, 1, 8'hAA, 3'd6, 1, 0, "sweep6");
    add(0, 1, 8'hAA, 3'd7, 1, 1, "sweep7");
    // Disable: outputs drop and ignore addy/D.
    add(0, 0, 8'hAA, 3'd7, 0, 0, "dis_a7");
    add(0, 0, 8'hAA, 3'd3, 0, 0, "dis_a3");
    add(0, 0, 8'hFF, 3'd5, 0, 0, "dis_ff");
    // Re-enable at addy=5: bit 5 of 8'hAA is 1.
    add(0, 1, 8'hAA, 3'd5, 1, 1, "reen_a5");
    // Data change at fixed addy=2.
    add(0, 1, 8'h04, 3'd2, 1, 1, "dchg0");
    add(0, 1, 8'h00, 3'd2, 1, 0, "dchg1");
    add(0, 1, 8'h04, 3'd2, 1, 1, "dchg2");
    add(0, 1, 8'h00, 3'd2, 1, 0, "dchg3");
    // Reset mid-stream.
    add(0, 1, 8'h02, 3'd1, 1, 1, "mid_pre");
    add(1, 1, 8'h02, 3'd1, 0, 0, "mid_rst");
    add(0, 1, 8'h02, 3'd1, 1, 1, "mid_post");
    // Boundaries: LSB/MSB and one-hot / one-cold patterns.
    add(0, 1, 8'h01, 3'd0, 1, 1, "lsb_one");
    add(0, 1, 8'hFE, 3'd0, 1, 0, "lsb_zero");
    add(0, 1, 8'h80, 3'd7, 1, 1, "msb_one");
    add(0, 1, 8'h7F, 3'd7, 1, 0, "msb_zero");
    add(0, 1, 8'h10, 3'd4, 1, 1, "onehot4");
    add(0, 1, 8'hEF, 3'd4, 1, 0, "onecold4");
    add(0, 1, 8'h40, 3'd6, 1, 1, "onehot6");
    add(0, 1, 8'h08, 3'd6, 1, 0, "off_by6");
    add(0, 0, 8'hFF, 3'd0, 0, 0, "dis_end");

    foreach (vecs[i]) begin
      @(negedge clk);
      rst  = vecs[i].rst;
      en   = vecs[i].en;
      D    = vecs[i].d;
      addy = vecs[i].addy;
      sb.push_back(vecs[i]);
    end

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
    end
    if (applied != vecs.size()) begin
      miscompares++;
      $display("FAIL count: checked %0d, want %0d", applied, vecs.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
